registro_universal_n: RTL and testbench
=======================================

# registro_universal_n

Parametrised universal register, successor to the fixed 4-bit register (Registro4Bit) used in the lab benches. It keeps that block's load/enable/reset behaviour and adds configurable width, a registered mode selector, serial shifting, rotation, increment/decrement and status flags. It is intended as the general-purpose storage/shift element for datapath exercises and serial links in the lab.

## Interface
- `ANCHO`, default 4: word width in bits, ≥ 2.
- `VALOR_REINICIO`, default 0: value loaded into `Rta` on reset, `ANCHO` bits.
- `Reloj`, input, 1: single clock; every register updates on the rising edge.
- `Reiniciar`, input, 1: synchronous, active-high reset.
- `Habilitar`, input, 1: when 0, all state holds regardless of `Modo`.
- `Modo`, input, 3: operation selector, sampled on the edge.
- `Tupla`, input, `ANCHO`: parallel load data.
- `SerieIzq`, input, 1: serial bit entering at the MSB on shift right.
- `SerieDer`, input, 1: serial bit entering at the LSB on shift left.
- `Rta`, output, `ANCHO`: register contents.
- `Acarreo`, output, 1: registered carry/borrow/shifted-out bit.
- `Cero`, output, 1: combinational, high when `Rta` is 0.

## Operation
Modes are applied when `Habilitar` is 1 and `Reiniciar` is 0:
- 000 HOLD: `Rta` and `Acarreo` unchanged.
- 001 LOAD: `Rta` ← `Tupla`; `Acarreo` ← 0.
- 010 SHL: `Rta` ← {`Rta`[ANCHO-2:0], `SerieDer`}; `Acarreo` ← old `Rta`[ANCHO-1].
- 011 SHR: `Rta` ← {`SerieIzq`, `Rta`[ANCHO-1:1]}; `Acarreo` ← old `Rta`[0].
- 100 ROL: `Rta` ← {`Rta`[ANCHO-2:0], `Rta`[ANCHO-1]}; `Acarreo` ← old MSB.
- 101 ROR: `Rta` ← {`Rta`[0], `Rta`[ANCHO-1:1]}; `Acarreo` ← old LSB.
- 110 INC: `Rta` ← `Rta`+1, modulo 2^ANCHO. `Acarreo` ← 1 only on the wrap from all-ones to 0, else 0.
- 111 DEC: `Rta` ← `Rta`−1, modulo 2^ANCHO. `Acarreo` ← 1 only on the borrow from 0 to all-ones, else 0.

Arithmetic is computed at ANCHO+1 bits. The extra bit is the carry or borrow.

Priority, highest first: `Reiniciar`, then `Habilitar`=0 (hold), then `Modo`.

`Cero` = (`Rta` == 0). It is purely combinational and has no extra flop.

## Timing
- Reset: on the first rising edge with `Reiniciar`=1, `Rta` ← `VALOR_REINICIO` and `Acarreo` ← 0. `Cero` follows, and is 1 when `VALOR_REINICIO` = 0.
- Before the first reset edge the outputs are undefined. The bench must not check them.
- Latency: every operation completes in one cycle. The new `Rta`/`Acarreo` are visible right after the edge that sampled `Modo`/`Tupla`/serial inputs.
- Back-to-back operations are allowed every cycle; there is no busy state.
- Reset mid-sequence, for example during an INC run, overrides the operation on that edge. The next edge resumes normally from `VALOR_REINICIO`.
- `Habilitar` falling to 0 freezes `Rta` and `Acarreo` on that edge. `Cero` keeps tracking the frozen `Rta`.
- Wrap boundaries:
  - INC at all-ones gives 0 with `Acarreo`=1.
  - DEC at 0 gives all-ones with `Acarreo`=1.
  - A following INC from 0 clears `Acarreo`.
- Inputs must be stable around the rising edge of `Reloj`. No internal synchronisers.

## Structure
- Shared package `registro_pkg`: mode constants `MODO_HOLD` … `MODO_DEC` (3-bit), and the mode enum type if the flow supports it.
- Sub-module `registro_universal_siguiente`: combinational next-state logic. It takes `Rta`, `Modo`, `Tupla` and the serial inputs, and returns next `Rta` and next `Acarreo`.
- Top level: the sequential part (reset, enable, flops) plus the `Cero` compare.

## Test plan
- Reset: `ANCHO`=4, `VALOR_REINICIO`=4'b1010, assert `Reiniciar` for one edge → `Rta`=1010, `Acarreo`=0, `Cero`=0. Repeat with `VALOR_REINICIO`=0 → `Cero`=1.
- Load and enable: LOAD `Tupla`=0110 with `Habilitar`=0 → `Rta` unchanged. Same with `Habilitar`=1 → `Rta`=0110 next edge.
- Shifts: `Rta`=1001.
  - SHL with `SerieDer`=1 → `Rta`=0011, `Acarreo`=1.
  - Then SHR with `SerieIzq`=0 → `Rta`=0001, `Acarreo`=1.
- Rotates: `Rta`=1000.
  - ROL → 0001, `Acarreo`=1.
  - ROR → 1000, `Acarreo`=1.
  - Four ROL from 0101 → 0101.
- Counting: LOAD 1110, then INC ×3 → 1111 (`Acarreo`=0), then 0000 (`Acarreo`=1, `Cero`=1), then 0001 (`Acarreo`=0). Then DEC ×2 → 0000, then 1111 with `Acarreo`=1.
- Reset mid-operation: INC run from 0011, assert `Reiniciar` on the third edge → `Rta`=`VALOR_REINICIO`. Deassert → INC resumes from the reset value. Also check width generality with `ANCHO`=8: INC from 8'hFF → 8'h00, `Acarreo`=1.

Source files
------------

// File: rtl/registro_pkg.sv
// rtl/registro_pkg.sv - mode encodings shared by the universal register and its next-state logic
package registro_pkg;

   localparam logic [2:0] MODO_HOLD = 3'b000;
   localparam logic [2:0] MODO_LOAD = 3'b001;
   localparam logic [2:0] MODO_SHL  = 3'b010;
   localparam logic [2:0] MODO_SHR  = 3'b011;
   localparam logic [2:0] MODO_ROL  = 3'b100;
   localparam logic [2:0] MODO_ROR  = 3'b101;
   localparam logic [2:0] MODO_INC  = 3'b110;
   localparam logic [2:0] MODO_DEC  = 3'b111;

   typedef logic [2:0] modo_t;

endpackage

// File: rtl/registro_universal_siguiente.sv
// rtl/registro_universal_siguiente.sv - combinational next value and carry for the universal register
module registro_universal_siguiente
   import registro_pkg::*;
#(
   parameter int ANCHO = 4
) (
   input  logic [ANCHO-1:0] rta_i,
   input  logic             acarreo_i,
   input  modo_t            modo_i,
   input  logic [ANCHO-1:0] tupla_i,
   input  logic             serie_izq_i,
   input  logic             serie_der_i,
   output logic [ANCHO-1:0] rta_d_o,
   output logic             acarreo_d_o
);

   logic [ANCHO:0] suma;
   logic [ANCHO:0] resta;

   // One extra bit so the top of the result is the carry (INC) or borrow (DEC)
   assign suma  = {1'b0, rta_i} + {{ANCHO{1'b0}}, 1'b1};
   assign resta = {1'b0, rta_i} - {{ANCHO{1'b0}}, 1'b1};

   always_comb begin
      rta_d_o     = rta_i;
      acarreo_d_o = acarreo_i;
      case (modo_i)
         MODO_HOLD: begin
            rta_d_o     = rta_i;
            acarreo_d_o = acarreo_i;
         end
         MODO_LOAD: begin
            rta_d_o     = tupla_i;
            acarreo_d_o = 1'b0;
         end
         MODO_SHL: begin
            rta_d_o     = {rta_i[ANCHO-2:0], serie_der_i};
            acarreo_d_o = rta_i[ANCHO-1];
         end
         MODO_SHR: begin
            rta_d_o     = {serie_izq_i, rta_i[ANCHO-1:1]};
            acarreo_d_o = rta_i[0];
         end
         MODO_ROL: begin
            rta_d_o     = {rta_i[ANCHO-2:0], rta_i[ANCHO-1]};
            acarreo_d_o = rta_i[ANCHO-1];
         end
         MODO_ROR: begin
            rta_d_o     = {rta_i[0], rta_i[ANCHO-1:1]};
            acarreo_d_o = rta_i[0];
         end
         MODO_INC: begin
            rta_d_o     = suma[ANCHO-1:0];
            acarreo_d_o = suma[ANCHO];
         end
         MODO_DEC: begin
            rta_d_o     = resta[ANCHO-1:0];
            acarreo_d_o = resta[ANCHO];
         end
         default: begin
            rta_d_o     = rta_i;
            acarreo_d_o = acarreo_i;
         end
      endcase
   end

endmodule

// File: rtl/registro_universal_n.sv
// rtl/registro_universal_n.sv - parametrised universal register: load, shift, rotate, count, zero flag
module registro_universal_n
   import registro_pkg::*;
#(
   parameter int               ANCHO          = 4,
   parameter logic [ANCHO-1:0] VALOR_REINICIO = '0
) (
   input  logic             Reloj,
   input  logic             Reiniciar,
   input  logic             Habilitar,
   input  logic [2:0]       Modo,
   input  logic [ANCHO-1:0] Tupla,
   input  logic             SerieIzq,
   input  logic             SerieDer,
   output logic [ANCHO-1:0] Rta,
   output logic             Acarreo,
   output logic             Cero
);

   logic [ANCHO-1:0] rta_q;
   logic [ANCHO-1:0] rta_d;
   logic             acarreo_q;
   logic             acarreo_d;

   registro_universal_siguiente #(
      .ANCHO (ANCHO)
   ) u_siguiente (
      .rta_i       (rta_q),
      .acarreo_i   (acarreo_q),
      .modo_i      (Modo),
      .tupla_i     (Tupla),
      .serie_izq_i (SerieIzq),
      .serie_der_i (SerieDer),
      .rta_d_o     (rta_d),
      .acarreo_d_o (acarreo_d)
   );

   // Reset beats enable, enable beats the selected mode
   always_ff @(posedge Reloj) begin
      if (Reiniciar) begin
         rta_q     <= VALOR_REINICIO;
         acarreo_q <= 1'b0;
      end else if (Habilitar) begin
         rta_q     <= rta_d;
         acarreo_q <= acarreo_d;
      end
   end

   assign Rta     = rta_q;
   assign Acarreo = acarreo_q;
   assign Cero    = (rta_q == '0);

endmodule

// File: tb/tb_registro_universal_n.sv
// tb/tb_registro_universal_n.sv - scoreboard bench for registro_universal_n against an arithmetic model
module tb_registro_universal_n;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [2:0] modo;
   logic [3:0] t4;
   logic [7:0] t8;
   logic       si;
   logic       sd;

   logic [3:0] rta_a, rta_z;
   logic [7:0] rta_8;
   logic       c_a, c_z, c_8;
   logic       z_a, z_z, z_8;

   always #5 clk = ~clk;

   registro_universal_n #(.ANCHO(4), .VALOR_REINICIO(4'b1010)) dut_a (
      .Reloj(clk), .Reiniciar(rst), .Habilitar(en), .Modo(modo), .Tupla(t4),
      .SerieIzq(si), .SerieDer(sd), .Rta(rta_a), .Acarreo(c_a), .Cero(z_a)
   );

   registro_universal_n #(.ANCHO(4), .VALOR_REINICIO(4'b0000)) dut_z (
      .Reloj(clk), .Reiniciar(rst), .Habilitar(en), .Modo(modo), .Tupla(t4),
      .SerieIzq(si), .SerieDer(sd), .Rta(rta_z), .Acarreo(c_z), .Cero(z_z)
   );

   registro_universal_n #(.ANCHO(8), .VALOR_REINICIO(8'h00)) dut_8 (
      .Reloj(clk), .Reiniciar(rst), .Habilitar(en), .Modo(modo), .Tupla(t8),
      .SerieIzq(si), .SerieDer(sd), .Rta(rta_8), .Acarreo(c_8), .Cero(z_8)
   );

   typedef struct {
      int    ra;
      int    ca;
      int    rz;
      int    cz;
      int    r8;
      int    c8;
      string tag;
   } exp_t;

   exp_t q[$];
   int   ma, mca, mz, mcz, m8, mc8;
   int   errors = 0;
   int   checks = 0;

   // Reference behaviour written as plain integer arithmetic on a w-bit value
   task automatic model(input int r_in, input int c_in, input int w, input int vr,
                        input bit rs, input bit e, input int m, input int t,
                        input int s_i, input int s_d, output int r_o, output int c_o);
      int top;
      int msb;
      top = 1 << w;
      msb = r_in / (top / 2);
      r_o = r_in;
      c_o = c_in;
      if (rs) begin
         r_o = vr;
         c_o = 0;
      end else if (e) begin
         case (m)
            1: begin r_o = t % top;                          c_o = 0; end
            2: begin r_o = (r_in * 2 + s_d) % top;           c_o = msb; end
            3: begin r_o = s_i * (top / 2) + r_in / 2;       c_o = r_in % 2; end
            4: begin r_o = (r_in * 2) % top + msb;           c_o = msb; end
            5: begin r_o = (r_in % 2) * (top / 2) + r_in / 2; c_o = r_in % 2; end
            6: begin r_o = (r_in + 1) % top;                 c_o = (r_in + 1 == top) ? 1 : 0; end
            7: begin r_o = (r_in + top - 1) % top;           c_o = (r_in == 0) ? 1 : 0; end
            default: ;
         endcase
      end
   endtask

   task automatic chk(input string name, input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s [%s]: got %0d, expected %0d", name, tag, got, exp);
      end
   endtask

   task automatic step(input bit r, input bit e, input logic [2:0] m, input logic [3:0] t,
                       input bit s_i, input bit s_d, input logic [7:0] tb8, input string tag);
      exp_t x;
      @(negedge clk);
      rst  = r;
      en   = e;
      modo = m;
      t4   = t;
      si   = s_i;
      sd   = s_d;
      t8   = tb8;
      model(ma, mca, 4, 10, r, e, int'(m), int'(t), int'(s_i), int'(s_d), ma, mca);
      model(mz, mcz, 4, 0, r, e, int'(m), int'(t), int'(s_i), int'(s_d), mz, mcz);
      model(m8, mc8, 8, 0, r, e, int'(m), int'(tb8), int'(s_i), int'(s_d), m8, mc8);
      x.ra = ma; x.ca = mca;
      x.rz = mz; x.cz = mcz;
      x.r8 = m8; x.c8 = mc8;
      x.tag = tag;
      q.push_back(x);
   endtask

   // Monitor: every edge that follows a queued stimulus produces one response to compare
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rta_a",   e.tag, int'(rta_a), e.ra);
            chk("carry_a", e.tag, int'(c_a),   e.ca);
            chk("cero_a",  e.tag, int'(z_a),   (e.ra == 0) ? 1 : 0);
            chk("rta_z",   e.tag, int'(rta_z), e.rz);
            chk("carry_z", e.tag, int'(c_z),   e.cz);
            chk("cero_z",  e.tag, int'(z_z),   (e.rz == 0) ? 1 : 0);
            chk("rta_8",   e.tag, int'(rta_8), e.r8);
            chk("carry_8", e.tag, int'(c_8),   e.c8);
            chk("cero_8",  e.tag, int'(z_8),   (e.r8 == 0) ? 1 : 0);
         end
      end
   end

   initial begin
      ma = 0; mca = 0; mz = 0; mcz = 0; m8 = 0; mc8 = 0;
      step(1, 0, 3'b000, 4'b0000, 0, 0, 8'h00, "reset");
      step(0, 0, 3'b001, 4'b0110, 0, 0, 8'h12, "load_disabled");
      step(0, 1, 3'b001, 4'b0110, 0, 0, 8'hFF, "load");
      step(0, 1, 3'b110, 4'b0000, 0, 0, 8'h00, "inc8_wrap");
      step(0, 1, 3'b001, 4'b1001, 0, 0, 8'h81, "load_1001");
      step(0, 1, 3'b010, 4'b0000, 0, 1, 8'h00, "shl");
      step(0, 1, 3'b011, 4'b0000, 0, 0, 8'h00, "shr");
      step(0, 1, 3'b001, 4'b1000, 0, 0, 8'h80, "load_1000");
      step(0, 1, 3'b100, 4'b0000, 0, 0, 8'h00, "rol");
      step(0, 1, 3'b101, 4'b0000, 0, 0, 8'h00, "ror");
      step(0, 1, 3'b001, 4'b0101, 0, 0, 8'h55, "load_0101");
      for (int i = 0; i < 4; i++) step(0, 1, 3'b100, 4'b0000, 0, 0, 8'h00, "rol4");
      step(0, 1, 3'b001, 4'b1110, 0, 0, 8'hFE, "load_1110");
      for (int i = 0; i < 3; i++) step(0, 1, 3'b110, 4'b0000, 0, 0, 8'h00, "inc");
      for (int i = 0; i < 2; i++) step(0, 1, 3'b111, 4'b0000, 0, 0, 8'h00, "dec");
      step(0, 1, 3'b110, 4'b0000, 0, 0, 8'h00, "inc_after_borrow");
      step(0, 1, 3'b001, 4'b0011, 0, 0, 8'h03, "load_0011");
      step(0, 1, 3'b110, 4'b0000, 0, 0, 8'h00, "inc_run1");
      step(0, 1, 3'b110, 4'b0000, 0, 0, 8'h00, "inc_run2");
      step(1, 1, 3'b110, 4'b0000, 0, 0, 8'h00, "inc_run_reset");
      step(0, 1, 3'b110, 4'b0000, 0, 0, 8'h00, "inc_resume1");
      step(0, 1, 3'b110, 4'b0000, 0, 0, 8'h00, "inc_resume2");
      step(0, 0, 3'b110, 4'b0000, 0, 0, 8'h00, "freeze");
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 24) == 0, $urandom_range(0, 4) != 0,
              3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom), 1'($urandom),
              8'($urandom), "random");
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", "end", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
